// File: rtl/trace_capture_fifo.sv
// trace_capture_fifo
//
// Captures per-cycle core debug records (pc, inst, aluOut, writeBack) into a
// DEPTH-record FIFO once a trigger PC is seen, then streams each record out as
// four 32-bit words over a valid/ready handshake.
//
// Optional feature: define TRACE_FILTER_EN to store only cycles where the core
// writes a register or memory (i_RegWEn || i_memRW). The default build stores
// every capture cycle.
//
// Ports
//   clk                     single clock, rising edge
//   reset                   synchronous, active-low
//   i_pc/i_inst/i_aluOut/i_writeBack  core debug words for this cycle
//   i_RegWEn, i_memRW       core write strobes (used by the filter only)
//   i_arm, i_stop, i_clear  capture control
//   i_trig_pc               trigger address
//   o_data, o_last          readout word, last word of the record
//   o_valid, i_ready        readout handshake
//   o_count                 records stored (0..DEPTH)
//   o_overflow              sticky: a record was dropped while full
//   o_state                 capture FSM state
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | not capturing; waiting for i_arm
// ARMED   | watching for i_pc == i_trig_pc
// CAPTURE | storing one record per cycle until i_stop

module trace_capture_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              i_pc,
  input  logic [31:0]              i_inst,
  input  logic [31:0]              i_aluOut,
  input  logic [31:0]              i_writeBack,
  input  logic                     i_RegWEn,
  input  logic                     i_memRW,
  input  logic                     i_arm,
  input  logic                     i_stop,
  input  logic                     i_clear,
  input  logic [31:0]              i_trig_pc,
  output logic [31:0]              o_data,
  output logic                     o_last,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic [1:0]               o_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    CAPTURE = 2'b10
  } state_t;

  state_t        r_state;
  logic [31:0]   r_mem [0:DEPTH-1][0:3];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [1:0]    r_idx;
  logic          r_overflow;

  logic w_match;
  logic w_capture;
  logic w_push_req;
  logic w_valid;
  logic w_hs;
  logic w_pop;
  logic w_full;
  logic w_push;

  assign w_match = (i_pc == i_trig_pc);

  // The trigger cycle itself is captured; clear and stop cycles never are.
  assign w_capture = !i_clear && !i_stop &&
                     ((r_state == CAPTURE) || ((r_state == ARMED) && w_match));

`ifdef TRACE_FILTER_EN
  assign w_push_req = w_capture && (i_RegWEn || i_memRW);
`else
  assign w_push_req = w_capture;
  logic w_unused_strobes;
  assign w_unused_strobes = i_RegWEn ^ i_memRW;
`endif

  assign w_valid = (r_count != '0);
  assign w_hs    = w_valid && i_ready;
  assign w_pop   = w_hs && (r_idx == 2'd3);
  assign w_full  = (r_count == FULL_CNT);
  // A completing pop frees a slot in the same cycle, so a full FIFO still
  // accepts the push.
  assign w_push  = reset && w_push_req && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_idx      <= '0;
      r_overflow <= 1'b0;
    end else if (i_clear) begin
      r_state    <= IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_idx      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (i_stop) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE:    if (i_arm)   r_state <= ARMED;
          ARMED:   if (w_match) r_state <= CAPTURE;
          CAPTURE: r_state <= CAPTURE;
          default: r_state <= IDLE;
        endcase
      end

      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_hs)   r_idx  <= r_idx + 2'd1;

      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

      if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // Storage is intentionally not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr][0] <= i_pc;
      r_mem[r_wptr][1] <= i_inst;
      r_mem[r_wptr][2] <= i_aluOut;
      r_mem[r_wptr][3] <= i_writeBack;
    end
  end

  assign o_valid    = w_valid;
  assign o_data     = w_valid ? r_mem[r_rptr][r_idx] : 32'd0;
  assign o_last     = w_valid && (r_idx == 2'd3);
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_state    = r_state;

endmodule

// File: tb/tb_trace_capture_fifo.sv
module tb_trace_capture_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_pc, i_inst, i_aluOut, i_writeBack, i_trig_pc;
  logic        i_RegWEn, i_memRW, i_arm, i_stop, i_clear, i_ready;
  logic [31:0] o_data;
  logic        o_last, o_valid, o_overflow;
  logic [4:0]  o_count;
  logic [1:0]  o_state;

  trace_capture_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .i_pc(i_pc), .i_inst(i_inst), .i_aluOut(i_aluOut), .i_writeBack(i_writeBack),
    .i_RegWEn(i_RegWEn), .i_memRW(i_memRW),
    .i_arm(i_arm), .i_stop(i_stop), .i_clear(i_clear), .i_trig_pc(i_trig_pc),
    .o_data(o_data), .o_last(o_last), .o_valid(o_valid), .i_ready(i_ready),
    .o_count(o_count), .o_overflow(o_overflow), .o_state(o_state)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of whole records plus a readout word index.
  typedef logic [3:0][31:0] rec_t;
  rec_t m_q[$];
  int   m_state;
  int   m_idx;
  bit   m_ov;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_flush();
    m_q.delete();
    m_state = 0;
    m_idx   = 0;
    m_ov    = 1'b0;
  endtask

  // Applies the inputs currently driven, as the DUT will see them at the next edge.
  task automatic model_step();
    bit match, hs, pop, cap, keep;
    if (!reset || i_clear) begin
      model_flush();
      return;
    end
    match = (i_pc == i_trig_pc);
    hs    = (m_q.size() > 0) && i_ready;
    pop   = hs && (m_idx == 3);
    cap   = !i_stop && (m_state == 2 || (m_state == 1 && match));
`ifdef TRACE_FILTER_EN
    keep = i_RegWEn || i_memRW;
`else
    keep = 1'b1;
`endif
    if (i_stop)                     m_state = 0;
    else if (m_state == 0 && i_arm) m_state = 1;
    else if (m_state == 1 && match) m_state = 2;

    if (cap && keep && m_q.size() == DEPTH && !pop) m_ov = 1'b1;
    if (pop) void'(m_q.pop_front());
    if (cap && keep && m_q.size() < DEPTH)
      m_q.push_back({i_writeBack, i_aluOut, i_inst, i_pc});
    if (hs) m_idx = (m_idx + 1) % 4;
  endtask

  task automatic cycle();
    bit ne;
    model_step();
    @(posedge clk);
    #1;
    ne = (m_q.size() > 0);
    check("count",    32'(o_count), 32'(m_q.size()));
    check("valid",    32'(o_valid), 32'(ne));
    check("data",     o_data, ne ? m_q[0][m_idx] : 32'd0);
    check("last",     32'(o_last), 32'(ne && m_idx == 3));
    check("overflow", 32'(o_overflow), 32'(m_ov));
    check("state",    32'(o_state), 32'(m_state));
  endtask

  task automatic defaults();
    i_arm = 0; i_stop = 0; i_clear = 0; i_ready = 0;
    i_RegWEn = 1; i_memRW = 0;
  endtask

  task automatic rnd_data();
    i_inst = $urandom; i_aluOut = $urandom; i_writeBack = $urandom;
  endtask

  task automatic do_clear();
    i_clear = 1; cycle(); i_clear = 0;
  endtask

  initial begin
    reset = 0; i_pc = 0; i_trig_pc = 0;
    defaults(); rnd_data();
    model_flush();
    cycle(); cycle();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data",  o_data, 32'd0);
    check("rst_last",  32'(o_last), 32'd0);
    reset = 1;
    cycle();

    // Trigger at 0x10: two records, drained with ready held high.
    i_trig_pc = 32'h10;
    i_arm = 1; i_pc = 32'h10; rnd_data(); cycle(); i_arm = 0;  // match on arm cycle is not captured
    check("arm_state", 32'(o_state), 32'd1);
    check("arm_nocap", 32'(o_count), 32'd0);
    i_pc = 32'h08; rnd_data(); cycle();
    i_pc = 32'h0C; rnd_data(); cycle();
    i_pc = 32'h10; rnd_data(); cycle();
    i_pc = 32'h14; rnd_data(); cycle();
    i_stop = 1; i_pc = 32'h18; rnd_data(); cycle(); i_stop = 0;
    check("s1_count", 32'(o_count), 32'd2);
    check("s1_word0", o_data, 32'h10);
    i_ready = 1;
    repeat (8) cycle();
    i_ready = 0;
    check("s1_drained", 32'(o_valid), 32'd0);

    // Overflow: 20 capture cycles into 16 slots.
    do_clear();
    i_trig_pc = 32'h100;
    i_arm = 1; i_pc = 0; cycle(); i_arm = 0;
    for (int k = 0; k < 20; k++) begin
      i_pc = 32'h100 + 32'(4 * k); rnd_data(); cycle();
    end
    i_stop = 1; cycle(); i_stop = 0;
    check("ovf_count", 32'(o_count), 32'd16);
    check("ovf_flag",  32'(o_overflow), 32'd1);
    check("ovf_head",  o_data, 32'h100);

    // Full FIFO: final-word pop coincides with a capture cycle.
    do_clear();
    i_trig_pc = 32'h200;
    i_arm = 1; i_pc = 0; cycle(); i_arm = 0;
    for (int k = 0; k < 16; k++) begin
      i_pc = 32'h200 + 32'(4 * k); rnd_data(); cycle();
    end
    i_stop = 1; cycle(); i_stop = 0;
    i_arm = 1; i_pc = 32'h4; cycle(); i_arm = 0;
    i_ready = 1;
    repeat (3) begin i_pc = 32'h4; rnd_data(); cycle(); end
    check("full_last", 32'(o_last), 32'd1);
    i_pc = 32'h200; rnd_data(); cycle();
    check("full_count", 32'(o_count), 32'd16);
    check("full_ovf",   32'(o_overflow), 32'd0);
    i_ready = 0;
    i_stop = 1; cycle(); i_stop = 0;

    // Drain with ready toggling every cycle.
    for (int k = 0; k < 132; k++) begin
      i_ready = ~i_ready; cycle();
    end
    i_ready = 0;
    check("toggle_empty", 32'(o_count), 32'd0);

    // Clear wins over stop and arm together.
    i_trig_pc = 32'h300;
    i_arm = 1; i_pc = 0; cycle(); i_arm = 0;
    for (int k = 0; k < 5; k++) begin
      i_pc = 32'h300 + 32'(4 * k); rnd_data(); cycle();
    end
    check("pre_clr_count", 32'(o_count), 32'd5);
    i_clear = 1; i_stop = 1; i_arm = 1; cycle();
    i_clear = 0; i_stop = 0; i_arm = 0;
    check("clr_count", 32'(o_count), 32'd0);
    check("clr_state", 32'(o_state), 32'd0);
    check("clr_ovf",   32'(o_overflow), 32'd0);

    // Write-strobe filter pattern 1,0,0,1 starting at the trigger cycle.
    i_trig_pc = 32'h400;
    i_arm = 1; i_pc = 0; cycle(); i_arm = 0;
    for (int k = 0; k < 4; k++) begin
      i_RegWEn = (k == 0 || k == 3); i_memRW = 0;
      i_pc = 32'h400 + 32'(4 * k); rnd_data(); cycle();
    end
    i_RegWEn = 1;
    i_stop = 1; cycle(); i_stop = 0;
`ifdef TRACE_FILTER_EN
    check("filter_count", 32'(o_count), 32'd2);
`else
    check("filter_count", 32'(o_count), 32'd4);
`endif

    // Reset in the middle of readout and capture.
    i_trig_pc = 32'h500;
    i_arm = 1; i_pc = 0; cycle(); i_arm = 0;
    i_pc = 32'h500; rnd_data(); cycle();
    i_ready = 1;
    i_pc = 32'h504; rnd_data(); cycle();
    i_pc = 32'h508; rnd_data(); cycle();
    reset = 0; cycle(); reset = 1; i_ready = 0;
    check("midrst_count", 32'(o_count), 32'd0);
    check("midrst_data",  o_data, 32'd0);
    check("midrst_state", 32'(o_state), 32'd0);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) i_trig_pc = 32'h10 + 32'(4 * $urandom_range(0, 1));
      i_pc     = 32'h10 + 32'(4 * $urandom_range(0, 3));
      rnd_data();
      i_arm    = ($urandom_range(0, 5) == 0);
      i_stop   = ($urandom_range(0, 24) == 0);
      i_clear  = ($urandom_range(0, 149) == 0);
      reset    = ($urandom_range(0, 399) != 0);
      i_ready  = ((k / 250) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      i_RegWEn = $urandom_range(0, 1);
      i_memRW  = $urandom_range(0, 1);
      cycle();
    end
    reset = 1; defaults();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
